// File: rtl/scl_edge_filter_if.sv
// Line-filter bus: enable and raw lines in, filtered levels and event pulses out.
interface scl_edge_filter_if #(
    parameter int NUM_CH = 2
);
    logic              en;
    logic [NUM_CH-1:0] line_in;
    logic [NUM_CH-1:0] line_filt;
    logic [NUM_CH-1:0] rising_edge_found;
    logic [NUM_CH-1:0] falling_edge_found;
    logic [NUM_CH-1:0] glitch_found;

    // Drives the raw lines and the enable, observes the filter results.
    modport master (
        output en,
        output line_in,
        input  line_filt,
        input  rising_edge_found,
        input  falling_edge_found,
        input  glitch_found
    );

    // The filter itself.
    modport slave (
        input  en,
        input  line_in,
        output line_filt,
        output rising_edge_found,
        output falling_edge_found,
        output glitch_found
    );
endinterface

// File: rtl/scl_edge_filter.sv
// Multi-channel bus-line conditioner: per channel a synchroniser chain
// followed by a consecutive-sample glitch filter, producing a clean level
// and one-cycle rising/falling/glitch pulses. All outputs are registered.
module scl_edge_filter #(
    parameter int              NUM_CH      = 2,
    parameter int              SYNC_STAGES = 2,
    parameter int              FILTER_LEN  = 3,
    parameter logic [NUM_CH-1:0] IDLE_VAL  = {NUM_CH{1'b1}}
) (
    input  logic                clk,
    input  logic                n_rst,
    scl_edge_filter_if.slave    bus
);

    // Counter only needs to reach FILTER_LEN-1; keep at least one bit.
    localparam int              CNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

    logic [NUM_CH-1:0] filt_vec;
    logic [NUM_CH-1:0] rise_vec;
    logic [NUM_CH-1:0] fall_vec;
    logic [NUM_CH-1:0] glitch_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   s;
            logic [CNT_W-1:0]       cnt_reg, cnt_next;
            logic                   filt_reg, filt_next;
            logic                   rise_reg, rise_next;
            logic                   fall_reg, fall_next;
            logic                   glitch_reg, glitch_next;

            assign s = sync_reg[SYNC_STAGES-1];

            // Synchroniser shift chain; runs regardless of enable.
            always_ff @(posedge clk) begin
                if (!n_rst) begin
                    sync_reg <= {SYNC_STAGES{IDLE_VAL[gi]}};
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.line_in[gi]};
                end
            end

            // Qualification: count consecutive differing samples, flip the
            // level once FILTER_LEN of them have been seen, report abandoned
            // pending changes as glitches. Disabled = clear count, hold level.
            always_comb begin
                cnt_next    = cnt_reg;
                filt_next   = filt_reg;
                rise_next   = 1'b0;
                fall_next   = 1'b0;
                glitch_next = 1'b0;
                if (!bus.en) begin
                    cnt_next = '0;
                end else if (s == filt_reg) begin
                    glitch_next = (cnt_reg != '0);
                    cnt_next    = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    filt_next = s;
                    cnt_next  = '0;
                    rise_next = s;
                    fall_next = ~s;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            // Filter state and registered pulse outputs.
            always_ff @(posedge clk) begin
                if (!n_rst) begin
                    cnt_reg    <= '0;
                    filt_reg   <= IDLE_VAL[gi];
                    rise_reg   <= 1'b0;
                    fall_reg   <= 1'b0;
                    glitch_reg <= 1'b0;
                end else begin
                    cnt_reg    <= cnt_next;
                    filt_reg   <= filt_next;
                    rise_reg   <= rise_next;
                    fall_reg   <= fall_next;
                    glitch_reg <= glitch_next;
                end
            end

            assign filt_vec[gi]   = filt_reg;
            assign rise_vec[gi]   = rise_reg;
            assign fall_vec[gi]   = fall_reg;
            assign glitch_vec[gi] = glitch_reg;
        end
    endgenerate

    assign bus.line_filt          = filt_vec;
    assign bus.rising_edge_found  = rise_vec;
    assign bus.falling_edge_found = fall_vec;
    assign bus.glitch_found       = glitch_vec;

endmodule

// File: tb/tb_scl_edge_filter.sv
// Directed bench: a 2-channel filter (2 sync stages, FILTER_LEN=3) and a
// 1-channel unfiltered build (FILTER_LEN=1) sharing one clock.
module tb_scl_edge_filter;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    logic nb_rst = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    scl_edge_filter_if #(.NUM_CH(2)) bus_a ();
    scl_edge_filter_if #(.NUM_CH(1)) bus_b ();

    scl_edge_filter #(
        .NUM_CH(2), .SYNC_STAGES(2), .FILTER_LEN(3), .IDLE_VAL(2'b11)
    ) dut_a (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_a)
    );

    scl_edge_filter #(
        .NUM_CH(1), .SYNC_STAGES(2), .FILTER_LEN(1), .IDLE_VAL(1'b1)
    ) dut_b (
        .clk   (clk),
        .n_rst (nb_rst),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int step,
                       input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp)
            $display("check %s step %0d: %b ok", tag, step, obs);
        else begin
            n_err++;
            $error("FAIL %s step %0d: observed %b expected %b", tag, step, obs, exp);
        end
    endtask

    // Check all four outputs of dut_a at once.
    task automatic chk_a(input string tag, input int step, input logic [1:0] filt,
                         input logic [1:0] rise, input logic [1:0] fall,
                         input logic [1:0] glitch);
        chk({tag, "_filt"},   step, bus_a.line_filt,          filt);
        chk({tag, "_rise"},   step, bus_a.rising_edge_found,  rise);
        chk({tag, "_fall"},   step, bus_a.falling_edge_found, fall);
        chk({tag, "_glitch"}, step, bus_a.glitch_found,       glitch);
    endtask

    task automatic chk_b(input string tag, input int step, input logic filt,
                         input logic rise, input logic fall);
        chk({tag, "_filt"},   step, {1'b0, bus_b.line_filt},          {1'b0, filt});
        chk({tag, "_rise"},   step, {1'b0, bus_b.rising_edge_found},  {1'b0, rise});
        chk({tag, "_fall"},   step, {1'b0, bus_b.falling_edge_found}, {1'b0, fall});
        chk({tag, "_glitch"}, step, {1'b0, bus_b.glitch_found},       2'b00);
    endtask

    initial begin
        bus_a.en      = 1'b1;
        bus_a.line_in = 2'b00;
        bus_b.en      = 1'b1;
        bus_b.line_in = 1'b1;

        // 1. Reset with lines low: idle level held, no pulses.
        for (int e = 0; e < 2; e++) begin
            tick();
            chk_a("t1_rst", e, 2'b11, 2'b00, 2'b00, 2'b00);
        end
        n_rst = 1'b1;
        bus_a.line_in = 2'b11;
        tick();
        chk_a("t1_post", 0, 2'b11, 2'b00, 2'b00, 2'b00);
        tick();

        // 2. Clean fall on ch0: pulse at edge 4 only, ch1 untouched.
        bus_a.line_in = 2'b10;
        for (int e = 0; e < 6; e++) begin
            tick();
            chk_a("t2_fall", e, (e >= 4) ? 2'b10 : 2'b11, 2'b00,
                  (e == 4) ? 2'b01 : 2'b00, 2'b00);
        end

        // 3. ch1 low for two samples then back high: glitch at edge 4.
        bus_a.line_in = 2'b00;
        for (int e = 0; e < 8; e++) begin
            if (e == 2) bus_a.line_in = 2'b10;
            tick();
            chk_a("t3_glitch", e, 2'b10, 2'b00, 2'b00,
                  (e == 4) ? 2'b10 : 2'b00);
        end

        // 4. Bring ch1 low, then both lines rise together.
        bus_a.line_in = 2'b00;
        for (int e = 0; e < 6; e++) tick();
        chk_a("t4_low", 0, 2'b00, 2'b00, 2'b00, 2'b00);
        bus_a.line_in = 2'b11;
        for (int e = 0; e < 6; e++) begin
            tick();
            chk_a("t4_rise", e, (e >= 4) ? 2'b11 : 2'b00,
                  (e == 4) ? 2'b11 : 2'b00, 2'b00, 2'b00);
        end

        // 5. Enable low while ch0 toggles then holds low: nothing happens.
        bus_a.en = 1'b0;
        bus_a.line_in = 2'b10;
        tick();
        bus_a.line_in = 2'b11;
        tick();
        bus_a.line_in = 2'b10;
        for (int e = 0; e < 10; e++) begin
            tick();
            chk_a("t5_off", e, 2'b11, 2'b00, 2'b00, 2'b00);
        end
        // Re-enable: synced value already differs, flip on the 3rd edge.
        bus_a.en = 1'b1;
        for (int e = 0; e < 5; e++) begin
            tick();
            chk_a("t5_on", e, (e >= 2) ? 2'b10 : 2'b11, 2'b00,
                  (e == 2) ? 2'b01 : 2'b00, 2'b00);
        end

        // 6. ch1 starts falling qualification, reset interrupts it.
        bus_a.line_in = 2'b00;
        for (int e = 0; e < 3; e++) begin
            tick();
            chk_a("t6_pend", e, 2'b10, 2'b00, 2'b00, 2'b00);
        end
        n_rst = 1'b0;
        tick();
        chk_a("t6_rst", 0, 2'b11, 2'b00, 2'b00, 2'b00);
        n_rst = 1'b1;
        bus_a.line_in = 2'b11;
        for (int e = 0; e < 5; e++) begin
            tick();
            chk_a("t6_after", e, 2'b11, 2'b00, 2'b00, 2'b00);
        end

        // 7. FILTER_LEN=1 build: every synced change flips, no glitches.
        nb_rst = 1'b1;
        tick();
        chk_b("t7_idle", 0, 1'b1, 1'b0, 1'b0);
        bus_b.line_in = 1'b0;
        for (int e = 0; e < 4; e++) begin
            tick();
            chk_b("t7_fall", e, (e >= 2) ? 1'b0 : 1'b1, 1'b0, (e == 2));
        end
        for (int e = 0; e < 6; e++) begin
            bus_b.line_in = (e == 0) ? 1'b1 : 1'b0;
            tick();
            chk_b("t7_pulse", e, (e == 2), (e == 2), (e == 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
